// File: rtl/fpu_add_arbiter.sv
// Round-robin arbiter sharing one FP add/sub controller between NUM_REQ requesters.
// One operation in flight; the result is routed back to the granted requester, and a watchdog aborts a hung op.
module fpu_add_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned GW             = 2,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                  CLK,
   input  logic                  RSTn,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*32-1:0] req_data1,
   input  logic [NUM_REQ*32-1:0] req_data2,
   input  logic [NUM_REQ*3-1:0]  req_mode,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [31:0]           rsp_data,
   output logic [2:0]            rsp_exc,
   output logic                  rsp_timeout,
   output logic [31:0]           fpu_datain1,
   output logic [31:0]           fpu_datain2,
   output logic [2:0]            fpu_mode,
   output logic                  fpu_data_valid,
   input  logic [31:0]           fpu_dataout,
   input  logic                  fpu_dataout_valid,
   input  logic [2:0]            fpu_exc,
   output logic                  busy,
   output logic [GW-1:0]         grant_id,
   output logic                  timeout_err
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [GW-1:0]        last_grant_q, last_grant_d;
   logic [GW-1:0]        grant_id_q, grant_id_d;
   logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
   logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [31:0]          rsp_data_q, rsp_data_d;
   logic [2:0]           rsp_exc_q, rsp_exc_d;
   logic                 rsp_timeout_q, rsp_timeout_d;
   logic [31:0]          fpu_datain1_q, fpu_datain1_d;
   logic [31:0]          fpu_datain2_q, fpu_datain2_d;
   logic [2:0]           fpu_mode_q, fpu_mode_d;
   logic                 fpu_data_valid_q, fpu_data_valid_d;
   logic                 busy_q, busy_d;
   logic                 timeout_err_q, timeout_err_d;

   logic                 found;
   logic [GW-1:0]        pick;
   logic [GW-1:0]        idx;

   // Rotating priority: scan from last_grant+1 upward, wrapping.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = GW'((32'(last_grant_q) + k) % NUM_REQ);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      last_grant_d     = last_grant_q;
      grant_id_d       = grant_id_q;
      req_ready_d      = '0;
      rsp_valid_d      = '0;
      rsp_data_d       = rsp_data_q;
      rsp_exc_d        = rsp_exc_q;
      rsp_timeout_d    = rsp_timeout_q;
      fpu_datain1_d    = fpu_datain1_q;
      fpu_datain2_d    = fpu_datain2_q;
      fpu_mode_d       = fpu_mode_q;
      fpu_data_valid_d = 1'b0;
      timeout_err_d    = timeout_err_q;

      case (state_q)
         S_IDLE: begin
            if (found) begin
               fpu_datain1_d      = req_data1[32*pick +: 32];
               fpu_datain2_d      = req_data2[32*pick +: 32];
               fpu_mode_d         = req_mode[3*pick +: 3];
               fpu_data_valid_d   = 1'b1;
               req_ready_d[pick]  = 1'b1;
               grant_id_d         = pick;
               last_grant_d       = pick;
               cnt_d              = '0;
               state_d            = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + CW'(1);
            // rsp_valid is registered on entry to RESP so it is visible during the RESP cycle.
            if (fpu_dataout_valid) begin
               rsp_data_d              = fpu_dataout;
               rsp_exc_d               = fpu_exc;
               rsp_timeout_d           = 1'b0;
               rsp_valid_d[grant_id_q] = 1'b1;
               state_d                 = S_RESP;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               rsp_data_d              = '0;
               rsp_exc_d               = '0;
               rsp_timeout_d           = 1'b1;
               timeout_err_d           = 1'b1;
               rsp_valid_d[grant_id_q] = 1'b1;
               state_d                 = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state_q          <= S_IDLE;
         cnt_q            <= '0;
         last_grant_q     <= GW'(NUM_REQ - 1);
         grant_id_q       <= '0;
         req_ready_q      <= '0;
         rsp_valid_q      <= '0;
         rsp_data_q       <= '0;
         rsp_exc_q        <= '0;
         rsp_timeout_q    <= 1'b0;
         fpu_datain1_q    <= '0;
         fpu_datain2_q    <= '0;
         fpu_mode_q       <= '0;
         fpu_data_valid_q <= 1'b0;
         busy_q           <= 1'b0;
         timeout_err_q    <= 1'b0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         last_grant_q     <= last_grant_d;
         grant_id_q       <= grant_id_d;
         req_ready_q      <= req_ready_d;
         rsp_valid_q      <= rsp_valid_d;
         rsp_data_q       <= rsp_data_d;
         rsp_exc_q        <= rsp_exc_d;
         rsp_timeout_q    <= rsp_timeout_d;
         fpu_datain1_q    <= fpu_datain1_d;
         fpu_datain2_q    <= fpu_datain2_d;
         fpu_mode_q       <= fpu_mode_d;
         fpu_data_valid_q <= fpu_data_valid_d;
         busy_q           <= busy_d;
         timeout_err_q    <= timeout_err_d;
      end
   end

   assign req_ready      = req_ready_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_data       = rsp_data_q;
   assign rsp_exc        = rsp_exc_q;
   assign rsp_timeout    = rsp_timeout_q;
   assign fpu_datain1    = fpu_datain1_q;
   assign fpu_datain2    = fpu_datain2_q;
   assign fpu_mode       = fpu_mode_q;
   assign fpu_data_valid = fpu_data_valid_q;
   assign busy           = busy_q;
   assign grant_id       = grant_id_q;
   assign timeout_err    = timeout_err_q;

endmodule
